vx_ibuffer_queue: RTL
=====================

# vx_ibuffer_queue

Per-warp instruction buffer that sits between decode and the scoreboard/issue stage, and acts as the transmitting (master) end of the ibuffer interface. Decoded instructions arrive on a single valid/ready input. Each one is queued in a small FIFO selected by its warp index. The block then presents one instruction per cycle to the ibuffer consumer, picking round-robin among non-empty warps. A per-warp flush port discards queued instructions after a branch or warp kill.

## Interface
- `NUM_WARPS`, default 4: warps served by this issue slice; must be a power of 2, ≥2.
- `DEPTH`, default 2: entries per warp FIFO; range 2..8.
- `clk` input, 1 bit: clock.
- `reset_n` input, 1 bit: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `in_valid` input, 1 bit: decoded instruction valid.
- `in_data` input, `data_t`: ibuffer payload (the shared ibuffer `data_t` struct). Field `wis` selects the destination queue.
- `in_ready` output, 1 bit: queue `in_data.wis` has space.
- `flush_valid` input, 1 bit: flush request.
- `flush_wid` input, `ISSUE_WIS_W` bits: warp to flush.
- `ibuffer_if` master modport: output `valid`, output `data` (`data_t`), input `ready`.
- `empty_mask` output, `NUM_WARPS` bits: bit w set when queue w holds 0 entries.

## Operation
- **Storage:** `NUM_WARPS` FIFOs, each `DEPTH` × `data_t`. Each FIFO has read pointer, write pointer and count. Count is `$clog2(DEPTH+1)` bits; pointers wrap modulo `DEPTH`.
- **Enqueue:**
  - `in_ready` = (count[`in_data.wis`] != `DEPTH`).
  - `in_ready` does not depend on `ibuffer_if.ready` or on flush.
  - Enqueue occurs when `in_valid && in_ready`.
- **Select:**
  - The round-robin pointer `rr` holds the last granted warp.
  - The candidate is the first non-empty warp scanning `rr+1`, `rr+2`, … with wrap.
  - `ibuffer_if.valid` = any queue non-empty.
  - `ibuffer_if.data` = head entry of the selected warp, with `wis` forced to the selected warp index.
- **Lock:** while `valid && !ready`, the selection is frozen on the presented warp. Valid and data stay stable, even if other warps become non-empty.
- **Dequeue:** on `valid && ready`, pop the head of the selected warp and set `rr` to that warp.
- **Same-warp enqueue and dequeue in one cycle:** count unchanged, both pointers advance.
- **Flush:**
  - `flush_valid` zeroes count and sets the read pointer equal to the write pointer for `flush_wid`.
  - Flush has priority over enqueue and dequeue to that warp in the same cycle. The incoming instruction is dropped even though `in_ready` was 1, and the dequeue is cancelled; `rr` is not updated.
  - If the flushed warp was locked on the output, the lock is released. Valid may drop, or switch to another warp, next cycle. This is the only exception to output stability; the consumer must accept it.
- **Reset (`reset_n` low, any cycle, including mid-transfer):**
  - All counts and pointers go to 0.
  - `rr` goes to `NUM_WARPS-1`, so warp 0 is first.
  - `ibuffer_if.valid`=0, `empty_mask`=all ones.
  - `in_ready` reflects empty queues, i.e. 1.
  - Storage contents are not reset.

## Timing
- **Enqueue-to-present latency:** 1 cycle. An entry written at edge N can be presented after edge N; there is no combinational bypass from `in_data` to `ibuffer_if.data`.
- **Throughput:** 1 enqueue and 1 dequeue per cycle.
- **Full queue:** a full queue accepts a new entry only the cycle after its pop.
- **`empty_mask`:** comes from registered counts and updates the cycle after enqueue, dequeue or flush.
- **Output path:** `ibuffer_if.valid` and `ibuffer_if.data` are combinational from registers only. `ready` affects only next-state.

## Structure
- **Package:** `data_t` and `ISSUE_WIS_W` come from the shared ibuffer `data_t` struct and `VX_gpu_pkg`. `DATAW = $bits(data_t)` is derived locally.
- **Sub-module:** one sub-module, `vx_ibuffer_fifo`, instantiated per warp. It provides push/pop/flush, full/empty and a head output, with async active-low reset.
- **Top level:** the round-robin select and lock logic live in the top level, implemented as a priority scan over a rotated mask.

## Test plan
- **Basic latency:** push warp 2, PC=0x80000000, ready=1 → valid at the next cycle with `wis`=2 and that PC; `empty_mask`=4'b1111 one cycle after the pop.
- **Full and back-pressure:** push 3 instructions to warp 1 with DEPTH=2 and ready=0 → `in_ready`=0 on the 3rd; after one pop, the 3rd is accepted; output order is preserved across the pop.
- **Round-robin fairness:** all 4 warps hold 2 entries, ready=1 → grant order 0,1,2,3,0,1,2,3; with ready toggling 0/1, data stays stable and `wis` holds during ready=0 cycles.
- **Flush collision:** flush warp 3 while it is presented with ready=1 and a push to warp 3 is in the same cycle → no handshake counted, warp 3 empty next cycle, output switches to the next non-empty warp.
- **Simultaneous push and pop:** push and pop to the same warp with count=DEPTH-1 → count unchanged, FIFO order correct; repeat across the pointer wrap.
- **Mid-transfer reset:** assert `reset_n` low asynchronously mid-transfer → `valid`=0 within the same cycle, `empty_mask`=all ones, first grant after release is warp 0.

Source files
------------

// File: rtl/vx_ibuffer_queue_pkg.sv
// Shared ibuffer payload type and issue-slice constants used by the
// instruction buffer, its per-warp FIFOs and the ibuffer interface.
package vx_ibuffer_queue_pkg;

  localparam int ISSUE_WARPS = 4;
  localparam int ISSUE_WIS_W = (ISSUE_WARPS > 1) ? $clog2(ISSUE_WARPS) : 1;

  typedef struct packed {
    logic [31:0]            pc;
    logic [ISSUE_WIS_W-1:0] wis;
    logic [7:0]             op_type;
    logic [4:0]             rd;
    logic                   wb;
  } data_t;

  // Output selection either scans round-robin or holds the presented warp.
  typedef enum logic {
    SEL_SCAN = 1'b0,
    SEL_HOLD = 1'b1
  } sel_state_e;

endpackage

// File: rtl/vx_ibuffer_if.sv
// Valid/ready ibuffer channel between the instruction buffer and issue.
interface vx_ibuffer_if;
  import vx_ibuffer_queue_pkg::*;

  logic  valid;
  data_t data;
  logic  ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/vx_ibuffer_fifo.sv
// Single-warp instruction FIFO with push/pop/flush; flush wins over both
// push and pop in the same cycle.
module vx_ibuffer_fifo #(
  parameter int DEPTH = 2,
  parameter int DATAW = 48
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [DATAW-1:0] data_i,
  output logic [DATAW-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [DATAW-1:0] mem_q [DEPTH];
  ptr_t rptr_q, rptr_d;
  ptr_t wptr_q, wptr_d;
  cnt_t count_q, count_d;
  logic push_ok, pop_ok;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full_o  = (count_q == cnt_t'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign head_o  = mem_q[rptr_q];

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = ptr_inc(wptr_q);
      if (pop_ok)  rptr_d = ptr_inc(rptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; validity is tracked entirely by the count,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/vx_ibuffer_queue.sv
// Per-warp instruction buffer: enqueues decoded instructions by warp and
// presents one per cycle to issue, round-robin across non-empty warps.
module vx_ibuffer_queue
  import vx_ibuffer_queue_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  data_t                  in_data,
  output logic                   in_ready,
  input  logic                   flush_valid,
  input  logic [ISSUE_WIS_W-1:0] flush_wid,
  vx_ibuffer_if.master           ibuffer_if,
  output logic [NUM_WARPS-1:0]   empty_mask
);

  localparam int DATAW = $bits(data_t);
  localparam int WID_W = $clog2(NUM_WARPS);

  typedef logic [WID_W-1:0] wid_t;

  logic [NUM_WARPS-1:0] push, pop, flush, full, empty;
  logic [DATAW-1:0]     head [NUM_WARPS];
  logic [DATAW-1:0]     in_bits;

  wid_t       in_wid, flush_w;
  wid_t       rr_q, rr_d;
  wid_t       lock_wid_q, lock_wid_d;
  wid_t       scan_wid, sel_wid;
  sel_state_e state_q, state_d;
  logic [NUM_WARPS-1:0] rot_mask;
  logic       out_valid, fire, sel_flushed, found;
  data_t      out_data;

  assign in_wid   = in_data.wis[WID_W-1:0];
  assign flush_w  = flush_wid[WID_W-1:0];
  assign in_bits  = in_data;
  assign in_ready = !full[in_wid];

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign push[w]  = in_valid && in_ready && (in_wid == wid_t'(w));
    assign flush[w] = flush_valid && (flush_w == wid_t'(w));
    assign pop[w]   = fire && (sel_wid == wid_t'(w)) && !flush[w];

    vx_ibuffer_fifo #(
      .DEPTH (DEPTH),
      .DATAW (DATAW)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push[w]),
      .pop_i   (pop[w]),
      .flush_i (flush[w]),
      .data_i  (in_bits),
      .head_o  (head[w]),
      .full_o  (full[w]),
      .empty_o (empty[w])
    );
  end

  // Rotate the non-empty mask so bit 0 is warp rr+1, then take the lowest set bit.
  always_comb begin
    rot_mask = '0;
    scan_wid = rr_q;
    found    = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      rot_mask[i] = !empty[rr_q + wid_t'(1) + wid_t'(i)];
    end
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (!found && rot_mask[i]) begin
        found    = 1'b1;
        scan_wid = rr_q + wid_t'(1) + wid_t'(i);
      end
    end
  end

  assign sel_wid     = (state_q == SEL_HOLD) ? lock_wid_q : scan_wid;
  assign out_valid   = |(~empty);
  assign fire        = out_valid && ibuffer_if.ready;
  assign sel_flushed = flush[sel_wid];

  always_comb begin
    out_data     = data_t'(head[sel_wid]);
    out_data.wis = ISSUE_WIS_W'(sel_wid);
  end

  assign ibuffer_if.valid = out_valid;
  assign ibuffer_if.data  = out_data;
  assign empty_mask       = empty;

  // A stalled presentation holds until accepted, unless its warp is flushed.
  always_comb begin
    state_d    = SEL_SCAN;
    lock_wid_d = sel_wid;
    rr_d       = rr_q;
    if (out_valid && !ibuffer_if.ready && !sel_flushed) state_d = SEL_HOLD;
    if (fire && !sel_flushed) rr_d = sel_wid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SEL_SCAN;
      lock_wid_q <= '0;
      rr_q       <= wid_t'(NUM_WARPS - 1);
    end else begin
      state_q    <= state_d;
      lock_wid_q <= lock_wid_d;
      rr_q       <= rr_d;
    end
  end

endmodule
